rf_writeback: RTL

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback_if.sv | 29 ++
 rtl/rf_writeback.sv | 80 ++++++++
 2 files changed

// File: rtl/rf_writeback_if.sv
// Writeback bus: ALU and load result offers, regfile write port, decode forwarding lookup.
interface rf_writeback_if #(
    parameter int REG_W  = 5,
    parameter int WORD_W = 32
);
    logic              alu_valid;
    logic [REG_W-1:0]  alu_rd;
    logic [WORD_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [REG_W-1:0]  mem_rd;
    logic [WORD_W-1:0] mem_data;
    logic              mem_ready;
    logic              regWrite;
    logic [REG_W-1:0]  waddr;
    logic [WORD_W-1:0] wdata;
    logic [REG_W-1:0]  fwd_addr;
    logic              fwd_hit;
    logic [WORD_W-1:0] fwd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_addr,
        output alu_ready, mem_ready, regWrite, waddr, wdata, fwd_hit, fwd_data
    );
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_addr,
        input  alu_ready, mem_ready, regWrite, waddr, wdata, fwd_hit, fwd_data
    );
endinterface

// File: rtl/rf_writeback.sv
// Pending-write queue between ALU/load results and the regfile write port.
// Pops one entry per cycle, accepts up to two per cycle (load older), forwards the youngest match.
module rf_writeback #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5,
    parameter int WORD_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_writeback_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_W-1:0]  r_rd   [DEPTH];
    logic [WORD_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_rp, r_wp;
    logic [CW-1:0]     r_cnt;

    logic              w_pop, w_need_mem, w_need_alu, w_acc_mem, w_acc_alu;
    logic [CW:0]       w_free;
    logic [PW-1:0]     w_wp_alu;
    logic              w_hit;
    logic [WORD_W-1:0] w_fdata;

    // The head leaves this edge, so its slot is usable by an incoming entry.
    assign w_pop      = (r_cnt != '0);
    assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_cnt} + (CW+1)'(w_pop);
    assign w_need_mem = bus.mem_valid && (bus.mem_rd != '0);
    assign w_need_alu = bus.alu_valid && (bus.alu_rd != '0);

    assign bus.mem_ready = rst_n && (w_free >= (CW+1)'(1));
    assign bus.alu_ready = rst_n && (w_free >= ((CW+1)'(1) + (CW+1)'(w_need_mem)));

    assign w_acc_mem = w_need_mem && bus.mem_ready;
    assign w_acc_alu = w_need_alu && bus.alu_ready;
    assign w_wp_alu  = r_wp + PW'(w_acc_mem);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rp  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
        end else begin
            r_rp  <= r_rp + PW'(w_pop);
            r_wp  <= r_wp + PW'(w_acc_mem) + PW'(w_acc_alu);
            r_cnt <= r_cnt + CW'(w_acc_mem) + CW'(w_acc_alu) - CW'(w_pop);
        end
    end

    // Storage needs no reset; accept strobes are already gated by rst_n.
    always_ff @(posedge clk) begin
        if (w_acc_mem) begin
            r_rd[r_wp]   <= bus.mem_rd;
            r_data[r_wp] <= bus.mem_data;
        end
        if (w_acc_alu) begin
            r_rd[w_wp_alu]   <= bus.alu_rd;
            r_data[w_wp_alu] <= bus.alu_data;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_cnt) && (r_rd[r_rp + PW'(i)] == bus.fwd_addr)) begin
                w_hit   = 1'b1;
                w_fdata = r_data[r_rp + PW'(i)];
            end
        end
    end

    assign bus.fwd_hit  = rst_n && w_hit && (bus.fwd_addr != '0);
    assign bus.fwd_data = bus.fwd_hit ? w_fdata : '0;
    assign bus.regWrite = rst_n && w_pop;
    assign bus.waddr    = bus.regWrite ? r_rd[r_rp] : '0;
    assign bus.wdata    = bus.regWrite ? r_data[r_rp] : '0;
endmodule
